// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Walks the PC, issues word reads to a variable-latency instruction memory
// over a req/ack handshake, and buffers the returned words together with their PC
// in a DEPTH-entry prefetch FIFO. The FIFO head is presented to decode with a
// valid/ready handshake. A redirect flushes the queue and restarts fetch at
// the target address.
//
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr  -> request to instruction memory (held until ack)
//   imem_ack/imem_rdata <- completion and instruction word
//   redirect/redirect_pc <- flush and restart fetch (bits [1:0] of pc ignored)
//   inst_valid/inst_ready/inst_out/inst_pc/inst_pc4 -> decode-side head
//   count -> entries currently held
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_out,
  output logic [31:0]              inst_pc,
  output logic [31:0]              inst_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [31:0]    req_addr;
  logic [31:0]    fifo_pc   [DEPTH];
  logic [31:0]    fifo_word [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  cnt;

  logic           push;
  logic           pop;
  logic [CW-1:0]  cnt_next;
  logic           room;
  logic           unused_pc_bits;

  // Low address bits of a redirect target are forced to zero.
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    pop      = (cnt != '0) && inst_ready;
    push     = (state == REQ) && imem_ack && !redirect;
    cnt_next = cnt + CW'(push) - CW'(pop);
    // Issue another request only if its word is guaranteed a free slot.
    room     = cnt_next < CW'(DEPTH);
  end

  assign imem_req   = (state != IDLE);
  assign imem_addr  = req_addr;
  assign inst_valid = (cnt != '0);
  assign inst_out   = fifo_word[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_pc4   = fifo_pc[rd_ptr] + 32'd4;
  assign count      = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[AW'(i)]   <= '0;
        fifo_word[AW'(i)] <= '0;
      end
    end else if (redirect) begin
      // Flush; a pop this cycle needs no bookkeeping since the queue empties.
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      case (state)
        REQ:     state <= imem_ack ? IDLE : DROP;
        DROP:    if (imem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else begin
      cnt <= cnt_next;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push) begin
        fifo_pc[wr_ptr]   <= req_addr;
        fifo_word[wr_ptr] <= imem_rdata;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      case (state)
        IDLE: begin
          if (room) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc <= req_addr + 32'd4;
            if (room) req_addr <= req_addr + 32'd4;
            else      state    <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (DEPTH=4, RESET_PC=0).
// A small memory responder returns addr-as-data after a programmable number
// of wait cycles; all other inputs are driven step by step.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [2:0]  count;

  int checks;
  int errors;
  int lat;
  int wcnt;
  logic prev_req;
  logic prev_ack;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance, then let the memory model respond for the new cycle.
  task automatic step();
    prev_req = imem_req;
    prev_ack = imem_ack;
    @(posedge clk);
    #1;
    if (prev_ack || !prev_req) wcnt = 0;
    else                       wcnt++;
    imem_ack   = imem_req && (wcnt >= lat);
    imem_rdata = imem_addr;
    chk("count_bound", {31'b0, count <= 3'd4}, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    lat = 0; wcnt = 0;

    // Reset state
    #12;
    chk("rst_req",   {31'b0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_count", {29'b0, count},      32'd0);
    chk("rst_out",   inst_out,            32'h0);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_pc4",   inst_pc4,            32'h4);
    reset = 1'b1;

    // Zero-wait memory, consumer always ready
    step();
    chk("zw_req1",   {31'b0, imem_req},   32'd1);
    chk("zw_addr1",  imem_addr,           32'h0);
    chk("zw_valid1", {31'b0, inst_valid}, 32'd0);
    step();
    chk("zw_valid2", {31'b0, inst_valid}, 32'd1);
    chk("zw_pc2",    inst_pc,             32'h0);
    chk("zw_out2",   inst_out,            32'h0);
    chk("zw_pc4_2",  inst_pc4,            32'h4);
    chk("zw_addr2",  imem_addr,           32'h4);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("zw_pc",    inst_pc,            32'(4 * k));
      chk("zw_out",   inst_out,           32'(4 * k));
      chk("zw_pc4",   inst_pc4,           32'(4 * k + 4));
      chk("zw_count", {29'b0, count},     32'd1);
    end

    // Asynchronous reset mid-stream, then fill with consumer stalled
    reset = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},   32'd0);
    chk("ar_count", {29'b0, count},      32'd0);
    chk("ar_valid", {31'b0, inst_valid}, 32'd0);
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("fill_req0",  {31'b0, imem_req}, 32'd1);
    chk("fill_cnt0",  {29'b0, count},    32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("fill_cnt", {29'b0, count},    32'(k));
      chk("fill_req", {31'b0, imem_req}, 32'd1);
    end
    step();
    chk("full_cnt", {29'b0, count},    32'd4);
    chk("full_req", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("full_hold_cnt", {29'b0, count},    32'd4);
      chk("full_hold_req", {31'b0, imem_req}, 32'd0);
    end
    chk("full_head", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    chk("drain_pc1",   inst_pc,            32'h4);
    chk("drain_cnt1",  {29'b0, count},     32'd3);
    chk("resume_req",  {31'b0, imem_req},  32'd1);
    chk("resume_addr", imem_addr,          32'h10);
    step();
    chk("drain_pc2",   inst_pc,            32'h8);
    chk("drain_cnt2",  {29'b0, count},     32'd3);
    step();
    chk("drain_pc3",   inst_pc,            32'hC);
    step();
    chk("drain_pc4",   inst_pc,            32'h10);
    chk("drain_out4",  inst_out,           32'h10);

    // Three-cycle ack latency
    reset = 1'b0;
    #1;
    imem_ack = 1'b0;
    lat = 2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lat_req",   {31'b0, imem_req},   32'd1);
      chk("lat_addr",  imem_addr,           32'h0);
      chk("lat_valid", {31'b0, inst_valid}, 32'd0);
    end
    step();
    chk("lat_v4",   {31'b0, inst_valid}, 32'd1);
    chk("lat_pc4",  inst_pc,             32'h0);
    step();
    chk("lat_v5",   {31'b0, inst_valid}, 32'd0);
    step();
    chk("lat_v6",   {31'b0, inst_valid}, 32'd0);
    chk("lat_a6",   imem_addr,           32'h4);
    step();
    chk("lat_v7",   {31'b0, inst_valid}, 32'd1);
    chk("lat_pc7",  inst_pc,             32'h4);
    chk("lat_out7", inst_out,            32'h4);

    // Redirect with a request outstanding and no ack: response is dropped
    redirect = 1'b1;
    redirect_pc = 32'h0000_0403;
    step();
    redirect = 1'b0;
    chk("drop_cnt",   {29'b0, count},      32'd0);
    chk("drop_valid", {31'b0, inst_valid}, 32'd0);
    chk("drop_req",   {31'b0, imem_req},   32'd1);
    chk("drop_addr",  imem_addr,           32'h8);
    step();
    chk("drop_addr2", imem_addr,           32'h8);
    step();
    chk("drop_idle",  {31'b0, imem_req},   32'd0);
    chk("drop_cnt2",  {29'b0, count},      32'd0);
    step();
    chk("tgt_req",    {31'b0, imem_req},   32'd1);
    chk("tgt_addr",   imem_addr,           32'h400);
    chk("tgt_cnt",    {29'b0, count},      32'd0);
    step();
    step();
    chk("tgt_cnt2",   {29'b0, count},      32'd0);
    lat = 0;
    step();
    chk("tgt_valid",  {31'b0, inst_valid}, 32'd1);
    chk("tgt_pc",     inst_pc,             32'h400);
    chk("tgt_out",    inst_out,            32'h400);
    chk("tgt_cnt3",   {29'b0, count},      32'd1);
    chk("tgt_next",   imem_addr,           32'h404);

    // Redirect coincident with ack and a pop
    chk("co_ack_pre", {31'b0, imem_ack},   32'd1);
    chk("co_pop_pre", inst_pc,             32'h400);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0800;
    step();
    redirect = 1'b0;
    chk("co_cnt",     {29'b0, count},      32'd0);
    chk("co_valid",   {31'b0, inst_valid}, 32'd0);
    chk("co_idle",    {31'b0, imem_req},   32'd0);
    step();
    chk("co_addr",    imem_addr,           32'h800);
    chk("co_req",     {31'b0, imem_req},   32'd1);
    step();
    chk("co_valid2",  {31'b0, inst_valid}, 32'd1);
    chk("co_pc",      inst_pc,             32'h800);
    chk("co_out",     inst_out,            32'h800);

    // Address wrap near the top of memory
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("wr_cnt",   {29'b0, count},    32'd0);
    step();
    chk("wr_addr0", imem_addr,         32'hFFFF_FFF8);
    step();
    chk("wr_pc0",   inst_pc,           32'hFFFF_FFF8);
    chk("wr_pc4_0", inst_pc4,          32'hFFFF_FFFC);
    chk("wr_addr1", imem_addr,         32'hFFFF_FFFC);
    step();
    chk("wr_pc1",   inst_pc,           32'hFFFF_FFFC);
    chk("wr_out1",  inst_out,          32'hFFFF_FFFC);
    chk("wr_pc4_1", inst_pc4,          32'h0);
    chk("wr_addr2", imem_addr,         32'h0);
    step();
    chk("wr_pc2",   inst_pc,           32'h0);
    chk("wr_pc4_2", inst_pc4,          32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
